// File: rtl/ghostbus_host_pkg.sv
// Shared definitions for the ghostbus host: FSM state encoding and default widths.
package ghostbus_host_pkg;

  // Host sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RWAIT = 2'd2,
    ST_RESP  = 2'd3
  } gb_state_e;

  // Default bus geometry
  localparam int GB_AW_DEF    = 12;
  localparam int GB_DW_DEF    = 32;
  localparam int LENW_DEF     = 8;
  localparam int RD_DELAY_DEF = 1;

  // Width of a counter able to hold 0..max_val (never narrower than one bit)
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ghostbus_host.sv
// Ghostbus initiator: turns a valid/ready command stream into single or
// auto-incrementing bus cycles and returns one response per read beat or a
// single ack per write command.
module ghostbus_host
  import ghostbus_host_pkg::*;
#(
  parameter int GB_AW    = GB_AW_DEF,
  parameter int GB_DW    = GB_DW_DEF,
  parameter int LENW     = LENW_DEF,
  parameter int RD_DELAY = RD_DELAY_DEF
) (
  input  logic             gb_clk,
  input  logic             gb_rst,
  // command stream
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [GB_AW-1:0] cmd_addr,
  input  logic [GB_DW-1:0] cmd_wdata,
  input  logic [LENW-1:0]  cmd_len,
  // response stream
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [GB_DW-1:0] rsp_rdata,
  output logic             rsp_we,
  output logic             rsp_last,
  // ghostbus
  output logic [GB_AW-1:0] gb_addr,
  output logic [GB_DW-1:0] gb_dout,
  output logic             gb_we,
  input  logic [GB_DW-1:0] gb_din
);

  localparam int DLYW = cnt_width(RD_DELAY);
  localparam logic [DLYW-1:0] DLY_END = DLYW'(RD_DELAY);

  gb_state_e        state_q;
  logic [GB_AW-1:0] gb_addr_q;
  logic [GB_DW-1:0] gb_dout_q;
  logic             gb_we_q;
  logic [LENW-1:0]  beat_q;
  logic [DLYW-1:0]  dly_q;
  logic             rsp_valid_q;
  logic [GB_DW-1:0] rsp_rdata_q;
  logic             rsp_we_q;
  logic             rsp_last_q;

  // Next-value helpers; address arithmetic wraps naturally at 2^GB_AW
  logic [GB_AW-1:0] addr_inc_d;
  logic [LENW-1:0]  beat_dec_d;
  logic [DLYW-1:0]  dly_inc_d;
  logic             beat_zero;

  assign addr_inc_d = gb_addr_q + GB_AW'(1);
  assign beat_dec_d = beat_q - LENW'(1);
  assign dly_inc_d  = dly_q + DLYW'(1);
  assign beat_zero  = (beat_q == '0);

  // Sequencer: all bus and response outputs are registered here
  always_ff @(posedge gb_clk or posedge gb_rst) begin
    if (gb_rst) begin
      state_q     <= ST_IDLE;
      gb_addr_q   <= '0;
      gb_dout_q   <= '0;
      gb_we_q     <= 1'b0;
      beat_q      <= '0;
      dly_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_we_q    <= 1'b0;
      rsp_last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // cmd_ready is high in IDLE, so cmd_valid alone is the handshake
          if (cmd_valid) begin
            gb_addr_q <= cmd_addr;
            beat_q    <= cmd_len;
            dly_q     <= '0;
            if (cmd_we) begin
              gb_dout_q <= cmd_wdata;
              gb_we_q   <= 1'b1;
              state_q   <= ST_WRITE;
            end else begin
              state_q   <= ST_RWAIT;
            end
          end
        end

        ST_WRITE: begin
          // One bus write per cycle; the same data is replicated to every beat
          if (beat_zero) begin
            gb_we_q     <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_we_q    <= 1'b1;
            rsp_last_q  <= 1'b1;
            rsp_rdata_q <= '0;
            state_q     <= ST_RESP;
          end else begin
            beat_q    <= beat_dec_d;
            gb_addr_q <= addr_inc_d;
          end
        end

        ST_RWAIT: begin
          // Address is held RD_DELAY+1 cycles; capture at the end of the last one
          if (dly_q == DLY_END) begin
            rsp_rdata_q <= gb_din;
            rsp_valid_q <= 1'b1;
            rsp_we_q    <= 1'b0;
            rsp_last_q  <= beat_zero;
            state_q     <= ST_RESP;
          end else begin
            dly_q <= dly_inc_d;
          end
        end

        ST_RESP: begin
          // Response fields stay frozen until the consumer takes them
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (!beat_zero) begin
              beat_q    <= beat_dec_d;
              gb_addr_q <= addr_inc_d;
              dly_q     <= '0;
              state_q   <= ST_RWAIT;
            end else begin
              state_q   <= ST_IDLE;
            end
          end
        end

        default: begin
          gb_we_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign gb_addr   = gb_addr_q;
  assign gb_dout   = gb_dout_q;
  assign gb_we     = gb_we_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_last  = rsp_last_q;

endmodule
